data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single-port synchronous data memory (1-cycle read latency) between two requesters: port A (CPU load/store stage) and port B (debug/program loader).
- Round-robin arbitration with optional A-priority.
- Port B can lock the memory for bursts, bounded by a starvation limit.
- Sits between the CPU core, the loader and the data memory array.

Parameters:
- ADDR_W, 9, data memory word-address width (512 words).
- DATA_W, 32, data word width.
- A_PRIORITY, 0, 1 = port A always wins conflicts (lock still honoured up to MAX_LOCK); 0 = round-robin.
- MAX_LOCK, 8, maximum consecutive locked grants to B while A is waiting; range 1..255.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- a_req  in  1  port A request valid.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_W  port A word address.
- a_wd  in  DATA_W  port A write data.
- a_gnt  out  1  port A request accepted this cycle (combinational).
- a_rvalid  out  1  port A read data valid (registered).
- a_rdata  out  DATA_W  port A read data.
- b_req, b_we, b_addr, b_wd, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- b_lock  in  1  B requests continued ownership while asserted with b_req.
- mem_we  out  1  to data memory write enable.
- mem_addr  out  ADDR_W  to data memory address.
- mem_wd  out  DATA_W  to data memory write data.
- mem_rd  in  DATA_W  from data memory, registered read data.
- conflict_cnt  out  16  saturating count of cycles where both ports requested.

Behaviour:
- Handshake: a transfer occurs on an edge where x_req and x_gnt are both 1. The requester holds req/we/addr/wd stable until granted. At most one gnt per cycle. gnt never asserts without req.
- Memory drive (combinational):
  - Granted port's addr/wd drive mem_addr/mem_wd; mem_we = granted_we.
  - No grant: mem_we=0, mem_addr=0, mem_wd=0.
- Reads:
  - A read accepted at edge T gives x_rvalid=1 for exactly one cycle after T, with x_rdata=mem_rd.
  - Back-to-back reads are allowed every cycle, one response per accepted read, in order.
  - x_rdata holds its last value when rvalid=0.
- Writes: no response; data is in memory after the accepting edge. A read of the same address granted on the next cycle returns the new data.
- Read-during-write ordering follows accept order; there is no bypass inside the arbiter.
- Arbitration state: last_winner (1 bit), lock_active (1 bit), lock_cnt (8 bits).
- Winner select:
  1. lock_active and b_req and lock_cnt<MAX_LOCK: B.
  2. Only one port requests: that port.
  3. Both request:
     - A_PRIORITY=1: A.
     - Otherwise the port that is not last_winner.
- last_winner updates on every transfer.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED→LOCKED: on a B transfer with b_lock=1. lock_cnt=0.
  - In LOCKED, lock_cnt increments on each B transfer while a_req=1; it does not increment when A is idle.
  - LOCKED→UNLOCKED when any of these holds:
    - b_lock=0 sampled with b_req;
    - b_req=0;
    - lock_cnt reaches MAX_LOCK. In this case A is granted next if requesting, and B must re-win arbitration to re-lock.
- conflict_cnt: increments when a_req && b_req; saturates at 16'hFFFF.
- Reset (resetn=0, any time, asynchronous):
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, conflict_cnt=0.
  - State UNLOCKED, lock_cnt=0, last_winner=B (so A wins the first conflict).
  - gnt and mem_we forced 0 while resetn=0.
  - An in-flight read is discarded: no rvalid after reset release.
- Simultaneous events: on the same-cycle lock release and A request, A is granted the following cycle, not the same one.

Decomposition:
- Shared package data_mem_pkg: PORT_A=1'b0, PORT_B=1'b1, ADDR_W/DATA_W defaults, lock state encoding (UNLOCKED, LOCKED).
- Sub-module data_mem_arb_pick: purely combinational winner select (inputs a_req, b_req, last_winner, lock_active, lock_cnt, A_PRIORITY, MAX_LOCK; outputs a_gnt, b_gnt). The top level holds all registers and muxes.

Test Plan:
- Reset then A read addr 5 (mem[5]=32'hDEAD_BEEF): a_gnt same cycle; a_rvalid=1 next cycle with a_rdata=32'hDEADBEEF; b_rvalid stays 0.
- A and B both request reads every cycle for 6 cycles, A_PRIORITY=0:
  - grants alternate A,B,A,B,A,B;
  - 6 rvalids routed to the correct ports;
  - conflict_cnt=6.
- B write addr 3 = 32'h1234 then A read addr 3 on the next cycle: a_rdata=32'h0000_1234.
- B locked burst of 20 writes, MAX_LOCK=8, A requesting throughout: B gets 8 grants, A granted exactly one cycle, then B re-wins and locks. The pattern repeats; A never waits more than 9 cycles.
- A_PRIORITY=1, continuous conflicts without lock: A granted every cycle, b_gnt=0 throughout.
- Assert resetn=0 between a read grant and its response: no rvalid after release; all outputs 0 during reset; conflict_cnt=0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter: port identifiers, default
// widths, counter widths and the lock state encoding.
package data_mem_pkg;

    // Port identifiers, used for last_winner
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Default data memory geometry (512 x 32)
    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 32;

    // Arbitration counter widths
    localparam int unsigned LOCK_CNT_W = 8;
    localparam int unsigned CONF_CNT_W = 16;

    // Port B lock state
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Increment that sticks at all-ones
    function automatic logic [CONF_CNT_W-1:0] sat_inc16(input logic [CONF_CNT_W-1:0] v);
        return (v == '1) ? v : v + CONF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/data_mem_arb_pick.sv
// Combinational winner select for the data memory arbiter.
//   a_req, b_req   : requests from port A (CPU) and port B (loader)
//   last_winner    : port that made the most recent transfer
//   lock_active    : port B currently holds the lock
//   lock_cnt       : locked B grants issued while A was waiting
//   a_gnt, b_gnt   : one-hot (or zero) grant, never without the matching request
module data_mem_arb_pick
    import data_mem_pkg::*;
#(
    parameter bit          A_PRIORITY = 1'b0,
    parameter int unsigned MAX_LOCK   = 8
) (
    input  logic                  a_req,
    input  logic                  b_req,
    input  logic                  last_winner,
    input  logic                  lock_active,
    input  logic [LOCK_CNT_W-1:0] lock_cnt,
    output logic                  a_gnt,
    output logic                  b_gnt
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_LIM = LOCK_CNT_W'(MAX_LOCK);

    // Lock beats everything until the starvation limit is used up
    always_comb begin : p_pick
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (lock_active && b_req && (lock_cnt < LOCK_LIM)) begin
            b_gnt = 1'b1;
        end else if (a_req && !b_req) begin
            a_gnt = 1'b1;
        end else if (!a_req && b_req) begin
            b_gnt = 1'b1;
        end else if (a_req && b_req) begin
            if (A_PRIORITY || (last_winner == PORT_B)) begin
                a_gnt = 1'b1;
            end else begin
                b_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port synchronous data memory (1-cycle read latency)
// between port A (CPU load/store) and port B (debug/program loader).
//   clk, resetn            : clock, asynchronous active-low reset
//   a_* / b_*              : request, write enable, address, write data,
//                            grant (combinational), read valid, read data
//   b_lock                 : B asks to keep ownership across a burst
//   mem_we/mem_addr/mem_wd : drive to the memory array
//   mem_rd                 : registered read data from the memory array
//   conflict_cnt           : saturating count of cycles with both requests
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter bit          A_PRIORITY = 1'b0,
    parameter int unsigned MAX_LOCK   = 8
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wd,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_W-1:0]     a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wd,
    input  logic                  b_lock,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_W-1:0]     b_rdata,

    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd,

    output logic [CONF_CNT_W-1:0] conflict_cnt
);

    localparam logic [LOCK_CNT_W-1:0] LOCK_LIM = LOCK_CNT_W'(MAX_LOCK);

    // Arbitration state
    lock_state_e            r_lock_state;
    logic [LOCK_CNT_W-1:0]  r_lock_cnt;
    logic                   r_last_winner;

    // Read response state
    logic                   r_a_rvalid;
    logic                   r_b_rvalid;
    logic [DATA_W-1:0]      r_a_rdata;
    logic [DATA_W-1:0]      r_b_rdata;
    logic [CONF_CNT_W-1:0]  r_conflict_cnt;

    logic                   w_a_pick;
    logic                   w_b_pick;
    logic [LOCK_CNT_W-1:0]  w_lock_cnt_inc;

    // Winner select
    data_mem_arb_pick #(
        .A_PRIORITY (A_PRIORITY),
        .MAX_LOCK   (MAX_LOCK)
    ) u_pick (
        .a_req       (a_req),
        .b_req       (b_req),
        .last_winner (r_last_winner),
        .lock_active (r_lock_state == LOCKED),
        .lock_cnt    (r_lock_cnt),
        .a_gnt       (w_a_pick),
        .b_gnt       (w_b_pick)
    );

    // Grants are held off for the whole reset window, not just at the edge
    assign a_gnt = w_a_pick & resetn;
    assign b_gnt = w_b_pick & resetn;

    // Memory drive: granted port passes through, idle bus is all zero
    always_comb begin : p_mem_mux
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (a_gnt) begin
            mem_we   = a_we;
            mem_addr = a_addr;
            mem_wd   = a_wd;
        end else if (b_gnt) begin
            mem_we   = b_we;
            mem_addr = b_addr;
            mem_wd   = b_wd;
        end
    end

    assign w_lock_cnt_inc = r_lock_cnt + LOCK_CNT_W'(1);

    // Lock FSM; the count only advances while A is actually being held off
    always_ff @(posedge clk or negedge resetn) begin : p_lock_fsm
        if (!resetn) begin
            r_lock_state <= UNLOCKED;
            r_lock_cnt   <= '0;
        end else begin
            case (r_lock_state)
                UNLOCKED: begin
                    if (b_gnt && b_lock) begin
                        r_lock_state <= LOCKED;
                        r_lock_cnt   <= '0;
                    end
                end
                LOCKED: begin
                    if (!b_req || !b_lock) begin
                        r_lock_state <= UNLOCKED;
                        r_lock_cnt   <= '0;
                    end else if (b_gnt && a_req) begin
                        // Limit reached: drop the lock so A wins the next conflict
                        if (w_lock_cnt_inc == LOCK_LIM) begin
                            r_lock_state <= UNLOCKED;
                            r_lock_cnt   <= '0;
                        end else begin
                            r_lock_cnt <= w_lock_cnt_inc;
                        end
                    end
                end
                default: begin
                    r_lock_state <= UNLOCKED;
                    r_lock_cnt   <= '0;
                end
            endcase
        end
    end

    // Round-robin history; reset to B so A takes the first conflict
    always_ff @(posedge clk or negedge resetn) begin : p_last_winner
        if (!resetn) begin
            r_last_winner <= PORT_B;
        end else if (a_gnt) begin
            r_last_winner <= PORT_A;
        end else if (b_gnt) begin
            r_last_winner <= PORT_B;
        end
    end

    // Read responses: valid one cycle after the accepting edge
    always_ff @(posedge clk or negedge resetn) begin : p_rsp
        if (!resetn) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_a_rvalid <= a_gnt & ~a_we;
            r_b_rvalid <= b_gnt & ~b_we;
            if (r_a_rvalid) begin
                r_a_rdata <= mem_rd;
            end
            if (r_b_rvalid) begin
                r_b_rdata <= mem_rd;
            end
        end
    end

    // mem_rd is already registered in the array; forward it in the valid
    // cycle and hold the last delivered word otherwise
    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = r_a_rvalid ? mem_rd : r_a_rdata;
    assign b_rdata  = r_b_rvalid ? mem_rd : r_b_rdata;

    // Conflict statistics
    always_ff @(posedge clk or negedge resetn) begin : p_conflict
        if (!resetn) begin
            r_conflict_cnt <= '0;
        end else if (a_req && b_req) begin
            r_conflict_cnt <= sat_inc16(r_conflict_cnt);
        end
    end

    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: round-robin instance plus an
// A-priority instance sharing the same request inputs, each with its own
// behavioural memory. Read data is checked against a shadow memory kept
// from the requesters' own write data.
module tb_data_mem_arbiter;

    localparam int unsigned AW        = 9;
    localparam int unsigned DW        = 32;
    localparam int unsigned MEM_WORDS = 512;

    logic          clk;
    logic          resetn;
    logic          a_req, a_we, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wd, b_wd;

    // Round-robin instance
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we;
    logic [DW-1:0] a_rdata, b_rdata, mem_wd, mem_rd;
    logic [AW-1:0] mem_addr;
    logic [15:0]   conflict_cnt;

    // A-priority instance
    logic          p_a_gnt, p_a_rvalid, p_b_gnt, p_b_rvalid, p_mem_we;
    logic [DW-1:0] p_a_rdata, p_b_rdata, p_mem_wd, p_mem_rd;
    logic [AW-1:0] p_mem_addr;
    logic [15:0]   p_conflict_cnt;

    logic [DW-1:0] mem0   [MEM_WORDS];
    logic [DW-1:0] mem1   [MEM_WORDS];
    logic [DW-1:0] shadow [MEM_WORDS];
    logic          preload;

    logic [DW-1:0] q_a [$];
    logic [DW-1:0] q_b [$];

    int errors = 0;
    int checks = 0;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .A_PRIORITY(1'b0), .MAX_LOCK(8)) u_dut (
        .clk(clk), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wd(b_wd), .b_lock(b_lock),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .conflict_cnt(conflict_cnt)
    );

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .A_PRIORITY(1'b1), .MAX_LOCK(8)) u_dut_pri (
        .clk(clk), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd),
        .a_gnt(p_a_gnt), .a_rvalid(p_a_rvalid), .a_rdata(p_a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wd(b_wd), .b_lock(b_lock),
        .b_gnt(p_b_gnt), .b_rvalid(p_b_rvalid), .b_rdata(p_b_rdata),
        .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wd(p_mem_wd), .mem_rd(p_mem_rd),
        .conflict_cnt(p_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 5) ? 32'hDEAD_BEEF : {16'hA5A5, 16'(i)};
    endfunction

    // Behavioural single-port memories, 1-cycle registered read
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem0[i] <= init_word(i);
                mem1[i] <= init_word(i);
            end
        end else begin
            if (mem_we)   mem0[mem_addr]   <= mem_wd;
            if (p_mem_we) mem1[p_mem_addr] <= p_mem_wd;
        end
        mem_rd   <= mem0[mem_addr];
        p_mem_rd <= mem1[p_mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push expected read data on accept, pop on rvalid
    always @(negedge clk) begin
        if (!resetn) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (a_rvalid) begin
                if (q_a.size() == 0) check("a_rvalid_unexpected", 32'(a_rvalid), 32'd0);
                else check("sb_a_rdata", a_rdata, q_a.pop_front());
            end
            if (b_rvalid) begin
                if (q_b.size() == 0) check("b_rvalid_unexpected", 32'(b_rvalid), 32'd0);
                else check("sb_b_rdata", b_rdata, q_b.pop_front());
            end
            if (a_gnt && !a_we) q_a.push_back(shadow[a_addr]);
            if (b_gnt && !b_we) q_b.push_back(shadow[b_addr]);
            if (a_gnt && a_we)  shadow[a_addr] = a_wd;
            if (b_gnt && b_we)  shadow[b_addr] = b_wd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_done, b_done, bw, ar, a_wait, max_wait;
        logic exp_a;

        for (int i = 0; i < MEM_WORDS; i++) shadow[i] = init_word(i);
        preload = 1'b1;
        resetn  = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wd = '0;
        b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_wd = '0; b_lock = 1'b0;
        @(posedge clk); #1 preload = 1'b0;

        // Reset state with both ports requesting
        @(negedge clk);
        check("rst_a_gnt", 32'(a_gnt), 32'd0);
        check("rst_b_gnt", 32'(b_gnt), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_conflict", 32'(conflict_cnt), 32'd0);
        @(posedge clk); #1 a_req = 1'b0; b_req = 1'b0; resetn = 1'b1;

        // A read of addr 5
        @(posedge clk); #1 a_req = 1'b1; a_we = 1'b0; a_addr = 9'd5;
        @(negedge clk);
        check("t1_a_gnt", 32'(a_gnt), 32'd1);
        check("t1_b_gnt", 32'(b_gnt), 32'd0);
        check("t1_mem_addr", 32'(mem_addr), 32'd5);
        check("t1_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1 a_req = 1'b0;
        @(negedge clk);
        check("t1_a_rvalid", 32'(a_rvalid), 32'd1);
        check("t1_a_rdata", a_rdata, 32'hDEAD_BEEF);
        check("t1_b_rvalid", 32'(b_rvalid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t1_a_rvalid_drop", 32'(a_rvalid), 32'd0);
        check("t1_a_rdata_hold", a_rdata, 32'hDEAD_BEEF);

        // B write addr 3, then A read of addr 3 on the next cycle
        @(posedge clk); #1 b_req = 1'b1; b_we = 1'b1; b_addr = 9'd3; b_wd = 32'h1234;
        @(negedge clk);
        check("t3_b_gnt", 32'(b_gnt), 32'd1);
        check("t3_mem_we", 32'(mem_we), 32'd1);
        check("t3_mem_addr", 32'(mem_addr), 32'd3);
        check("t3_mem_wd", mem_wd, 32'h1234);
        @(posedge clk); #1 b_req = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 9'd3;
        @(negedge clk);
        check("t3_a_gnt", 32'(a_gnt), 32'd1);
        @(posedge clk); #1 a_req = 1'b0;
        @(negedge clk);
        check("t3_a_rvalid", 32'(a_rvalid), 32'd1);
        check("t3_a_rdata", a_rdata, 32'h0000_1234);

        // Six cycles of conflicting reads; A won last, so B leads
        a_done = 0; b_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1
            a_req = 1'b1; a_we = 1'b0; a_addr = AW'(10 + a_done);
            b_req = 1'b1; b_we = 1'b0; b_addr = AW'(20 + b_done);
            @(negedge clk);
            check($sformatf("rr_a_gnt[%0d]", i), 32'(a_gnt), 32'((i % 2) == 1));
            check($sformatf("rr_b_gnt[%0d]", i), 32'(b_gnt), 32'((i % 2) == 0));
            if (a_gnt) a_done++;
            if (b_gnt) b_done++;
        end
        @(posedge clk); #1 a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        check("rr_conflict_cnt", 32'(conflict_cnt), 32'd6);

        // Locked B burst of 20 writes with A reading throughout:
        // B re-wins, holds 8 more locked grants, then A gets one cycle
        bw = 0; ar = 0; a_wait = 0; max_wait = 0;
        for (int k = 0; k < 40 && bw < 20; k++) begin
            @(posedge clk); #1
            a_req = 1'b1; a_we = 1'b0; a_addr = AW'(100 + 9 * ar);
            b_req = 1'b1; b_we = 1'b1; b_lock = 1'b1;
            b_addr = AW'(100 + bw); b_wd = 32'hB000_0000 | 32'(bw);
            @(negedge clk);
            exp_a = ((k % 10) == 9);
            check($sformatf("lk_a_gnt[%0d]", k), 32'(a_gnt), 32'(exp_a));
            check($sformatf("lk_b_gnt[%0d]", k), 32'(b_gnt), 32'(!exp_a));
            if (a_gnt) begin
                if (a_wait > max_wait) max_wait = a_wait;
                a_wait = 0;
                ar++;
            end else begin
                a_wait++;
            end
            if (b_gnt) bw++;
        end
        check("lk_burst_done", 32'(bw), 32'd20);
        check("lk_a_max_wait_le9", 32'(max_wait <= 9), 32'd1);
        @(posedge clk); #1 b_req = 1'b0; b_lock = 1'b0;
        @(negedge clk);
        check("lk_a_gnt_after", 32'(a_gnt), 32'd1);
        @(posedge clk); #1 a_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset between a read grant and its response
        @(posedge clk); #1 a_req = 1'b1; a_we = 1'b0; a_addr = 9'd5;
        @(negedge clk);
        check("rs_a_gnt", 32'(a_gnt), 32'd1);
        @(posedge clk); #1 resetn = 1'b0; b_req = 1'b1; b_we = 1'b0;
        @(negedge clk);
        check("rs_a_gnt_low", 32'(a_gnt), 32'd0);
        check("rs_b_gnt_low", 32'(b_gnt), 32'd0);
        check("rs_mem_we", 32'(mem_we), 32'd0);
        check("rs_mem_addr", 32'(mem_addr), 32'd0);
        check("rs_a_rvalid", 32'(a_rvalid), 32'd0);
        check("rs_b_rvalid", 32'(b_rvalid), 32'd0);
        check("rs_a_rdata", a_rdata, 32'd0);
        check("rs_b_rdata", b_rdata, 32'd0);
        check("rs_conflict", 32'(conflict_cnt), 32'd0);
        check("rs_pri_a_gnt", 32'(p_a_gnt), 32'd0);
        @(posedge clk); #1 a_req = 1'b0; b_req = 1'b0; resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("rs_no_rvalid[%0d]", i), 32'(a_rvalid), 32'd0);
            @(posedge clk);
        end

        // Conflicting reads without lock: priority instance always picks A,
        // round-robin instance alternates starting with A after reset
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1
            a_req = 1'b1; a_we = 1'b0; a_addr = 9'd7;
            b_req = 1'b1; b_we = 1'b0; b_addr = 9'd8; b_lock = 1'b0;
            @(negedge clk);
            check($sformatf("pri_a_gnt[%0d]", i), 32'(p_a_gnt), 32'd1);
            check($sformatf("pri_b_gnt[%0d]", i), 32'(p_b_gnt), 32'd0);
            check($sformatf("rr2_a_gnt[%0d]", i), 32'(a_gnt), 32'((i % 2) == 0));
        end
        @(posedge clk); #1 a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        check("pri_conflict_cnt", 32'(p_conflict_cnt), 32'd6);
        check("rr2_conflict_cnt", 32'(conflict_cnt), 32'd6);
        repeat (2) @(negedge clk);
        check("sb_a_empty", 32'(q_a.size()), 32'd0);
        check("sb_b_empty", 32'(q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
